// File: rtl/bcd_serial_alu.sv
// bcd_serial_alu
//   Digit-serial binary/BCD add/subtract unit for the 65C816 ADC/SBC path.
//   One 4-bit digit is processed per clock, least significant digit first.
//   Operands and mode bits are latched on START; DONE pulses for one cycle
//   when the result and flags are written.
//
// Ports
//   CLK    rising-edge clock
//   RST_N  asynchronous active-low reset
//   START  request, sampled only while idle
//   ADD    1 = add, 0 = subtract (A - B - ~CI)
//   BCD    1 = decimal mode, 0 = binary
//   W8     1 = operate on the low byte only (2 digits)
//   CI     carry in (subtract: 1 = no borrow)
//   A, B   operands, 4*DIGITS bits
//   S      result, held until the next completion
//   CO     carry out (subtract: 1 = no borrow)
//   VO     signed overflow
//   NO     result MSB (bit 7 in byte mode)
//   ZO     result zero (low byte in byte mode)
//   BUSY   operation in progress
//   DONE   one-cycle completion pulse
module bcd_serial_alu #(
  parameter int DIGITS = 4
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                START,
  input  logic                ADD,
  input  logic                BCD,
  input  logic                W8,
  input  logic                CI,
  input  logic [4*DIGITS-1:0] A,
  input  logic [4*DIGITS-1:0] B,
  output logic [4*DIGITS-1:0] S,
  output logic                CO,
  output logic                VO,
  output logic                NO,
  output logic                ZO,
  output logic                BUSY,
  output logic                DONE
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS);
  localparam logic [W-1:0] LOW_BYTE = W'(8'hFF);

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state, state_nxt;
  logic [W-1:0]    a_lat, b_lat, acc;
  logic            add_lat, bcd_lat, w8_lat, carry;
  logic [CW-1:0]   cnt;

  logic [3:0]      a_dig, b_dig, res_dig;
  logic            dig_co, dig_v, last;
  logic [W-1:0]    acc_nxt, res_full;

  // One digit of add/subtract with decimal correction.
  // Returns {overflow, carry_out, digit}; overflow uses the uncorrected sum.
  function automatic logic [5:0] digit_op(input logic [3:0] a, input logic [3:0] b,
                                          input logic c, input logic add, input logic bcd);
    logic [3:0] bp;
    logic [4:0] sum;
    logic       dc, co, v;
    logic [3:0] d;
    bp  = b ^ {4{~add}};
    sum = {1'b0, a} + {1'b0, bp} + {4'b0000, c};
    if (add) begin
      dc = sum[4] | (sum[3] & (sum[2] | sum[1]));
      d  = (bcd && dc) ? sum[3:0] + 4'd6 : sum[3:0];
      co = bcd ? dc : sum[4];
    end else begin
      // A missing binary carry is a borrow; the 10's-complement fix is +10.
      dc = ~sum[4];
      d  = (bcd && dc) ? sum[3:0] + 4'd10 : sum[3:0];
      co = sum[4];
    end
    v = ~(a[3] ^ bp[3]) & (a[3] ^ sum[3]);
    return {v, co, d};
  endfunction

  // Digit select and combinational digit result
  always_comb begin
    a_dig = a_lat[{cnt, 2'b00} +: 4];
    b_dig = b_lat[{cnt, 2'b00} +: 4];
    {dig_v, dig_co, res_dig} = digit_op(a_dig, b_dig, carry, add_lat, bcd_lat);
    acc_nxt = acc;
    acc_nxt[{cnt, 2'b00} +: 4] = res_dig;
    last = (cnt == (w8_lat ? CW'(1) : CW'(DIGITS - 1)));
    // Byte mode keeps the latched upper accumulator bits untouched.
    res_full = w8_lat ? ((a_lat & ~LOW_BYTE) | (acc_nxt & LOW_BYTE)) : acc_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (START) state_nxt = RUN;
      RUN:     if (last)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nxt;
  end

  assign BUSY = (state == RUN);

  // Operand latch, digit accumulation and result write-back
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      a_lat   <= '0;
      b_lat   <= '0;
      acc     <= '0;
      add_lat <= 1'b0;
      bcd_lat <= 1'b0;
      w8_lat  <= 1'b0;
      carry   <= 1'b0;
      cnt     <= '0;
      S       <= '0;
      CO      <= 1'b0;
      VO      <= 1'b0;
      NO      <= 1'b0;
      ZO      <= 1'b0;
      DONE    <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (START) begin
            a_lat   <= A;
            b_lat   <= B;
            add_lat <= ADD;
            bcd_lat <= BCD;
            w8_lat  <= W8;
            carry   <= CI;
            cnt     <= '0;
            acc     <= '0;
          end
        end
        RUN: begin
          acc   <= acc_nxt;
          carry <= dig_co;
          cnt   <= cnt + 1'b1;
          if (last) begin
            S    <= res_full;
            CO   <= dig_co;
            VO   <= dig_v;
            // The final digit's MSB is bit 7 in byte mode and bit W-1 otherwise.
            NO   <= res_dig[3];
            ZO   <= w8_lat ? ((acc_nxt & LOW_BYTE) == '0) : (acc_nxt == '0);
            DONE <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_serial_alu.sv
// tb_bcd_serial_alu
//   Scoreboard bench for bcd_serial_alu (DIGITS = 4). Stimulus pushes the
//   expected result for each accepted operation; a monitor pops and compares
//   on every DONE pulse and checks that S holds between completions.
module tb_bcd_serial_alu;

  localparam int DIGITS = 4;
  localparam int W = 4 * DIGITS;

  typedef struct packed {
    logic [W-1:0] s;
    logic         co;
    logic         vo;
    logic         no;
    logic         zo;
  } exp_t;

  logic         CLK = 1'b0;
  logic         RST_N = 1'b0;
  logic         START = 1'b0;
  logic         ADD = 1'b0;
  logic         BCD = 1'b0;
  logic         W8 = 1'b0;
  logic         CI = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic [W-1:0] S;
  logic         CO, VO, NO, ZO, BUSY, DONE;

  int   checks = 0;
  int   errors = 0;
  int   done_count = 0;
  int   pushed = 0;
  exp_t q[$];
  logic [W-1:0] last_s = '0;

  bcd_serial_alu #(.DIGITS(DIGITS)) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .ADD(ADD), .BCD(BCD), .W8(W8),
    .CI(CI), .A(A), .B(B), .S(S), .CO(CO), .VO(VO), .NO(NO), .ZO(ZO),
    .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  // ---------------- reference model (decimal / integer arithmetic) --------
  function automatic longint pow10(input int n);
    longint p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  function automatic longint bcd2int(input longint v, input int n);
    longint r;
    r = 0;
    for (int i = n - 1; i >= 0; i--) r = r * 10 + ((v >> (4 * i)) & 15);
    return r;
  endfunction

  function automatic longint int2bcd(input longint v, input int n);
    longint r, x;
    r = 0;
    x = v;
    for (int i = 0; i < n; i++) begin
      r = r | ((x % 10) << (4 * i));
      x = x / 10;
    end
    return r;
  endfunction

  function automatic exp_t ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                     input logic add, input logic bcd,
                                     input logic w8, input logic ci);
    exp_t   e;
    int     n;
    longint am, bm, c, av, bv, r, md, lo, sa, sb, sr, at, bt, bs, res;
    logic   co, ctop, vo;
    n  = w8 ? 2 : 4;
    am = w8 ? longint'(a[7:0]) : longint'(a);
    bm = w8 ? longint'(b[7:0]) : longint'(b);
    c  = longint'(ci);
    if (bcd) begin
      md = pow10(n);
      lo = pow10(n - 1);
      av = bcd2int(am, n);
      bv = bcd2int(bm, n);
      if (add) begin
        r    = av + bv + c;
        co   = (r >= md);
        if (co) r = r - md;
        ctop = ((av % lo) + (bv % lo) + c) >= lo;
      end else begin
        r    = av - bv - (1 - c);
        co   = (r >= 0);
        if (!co) r = r + md;
        ctop = ((av % lo) - (bv % lo) - (1 - c)) >= 0;
      end
      res = int2bcd(r, n);
      at  = (am >> (4 * (n - 1))) & 15;
      bt  = ((bm >> (4 * (n - 1))) & 15) ^ (add ? 0 : 15);
      bs  = (at + bt + longint'(ctop)) & 15;
      vo  = ((at >> 3) == (bt >> 3)) && ((at >> 3) != (bs >> 3));
    end else begin
      md = longint'(1) << (4 * n);
      sa = (am >= md / 2) ? am - md : am;
      sb = (bm >= md / 2) ? bm - md : bm;
      if (add) begin
        r  = am + bm + c;
        co = (r >= md);
        if (co) r = r - md;
        sr = sa + sb + c;
      end else begin
        r  = am - bm - (1 - c);
        co = (r >= 0);
        if (!co) r = r + md;
        sr = sa - sb - (1 - c);
      end
      vo  = (sr < -(md / 2)) || (sr >= md / 2);
      res = r;
    end
    e.s  = w8 ? {a[W-1:8], 8'(res)} : W'(res);
    e.co = co;
    e.vo = vo;
    e.no = ((res >> (4 * n - 1)) & 1) != 0;
    e.zo = (res == 0);
    return e;
  endfunction

  // ---------------- monitor / scoreboard ----------------------------------
  always @(negedge CLK) begin
    exp_t e;
    if (!RST_N) begin
      last_s = '0;
    end else if (DONE) begin
      done_count++;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got S=%h with no operation pending", S);
      end else begin
        e = q.pop_front();
        if ({S, CO, VO, NO, ZO} !== e) begin
          errors++;
          $display("FAIL result: got S=%h C=%b V=%b N=%b Z=%b, expected S=%h C=%b V=%b N=%b Z=%b",
                   S, CO, VO, NO, ZO, e.s, e.co, e.vo, e.no, e.zo);
        end
        last_s = e.s;
      end
    end else begin
      checks++;
      if (S !== last_s) begin
        errors++;
        $display("FAIL s_hold: got S=%h, expected held S=%h", S, last_s);
      end
    end
  end

  // ---------------- stimulus helpers --------------------------------------
  task automatic scramble();
    A   = W'($urandom);
    B   = W'($urandom);
    ADD = 1'($urandom);
    BCD = 1'($urandom);
    W8  = 1'($urandom);
    CI  = 1'($urandom);
  endtask

  task automatic check_busy(input logic want, input string name);
    checks++;
    if (BUSY !== want) begin
      errors++;
      $display("FAIL %s: got BUSY=%b, expected %b", name, BUSY, want);
    end
  endtask

  // Called at the first negedge after the accepting edge.
  task automatic wait_done(input int exp_edges);
    int edges;
    edges = 1;
    while (!DONE && edges < 40) begin
      @(negedge CLK);
      edges++;
    end
    checks++;
    if (!DONE || edges != exp_edges) begin
      errors++;
      $display("FAIL latency: got DONE=%b after %0d edges, expected DONE after %0d edges",
               DONE, edges, exp_edges);
    end
    check_busy(1'b0, "busy_at_done");
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic add,
                       input logic bcd, input logic w8, input logic ci, input exp_t e);
    @(negedge CLK);
    A = a; B = b; ADD = add; BCD = bcd; W8 = w8; CI = ci;
    START = 1'b1;
    q.push_back(e);
    pushed++;
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic add,
                        input logic bcd, input logic w8, input logic ci, input exp_t e);
    issue(a, b, add, bcd, w8, ci, e);
    @(negedge CLK);
    START = 1'b0;
    scramble();
    check_busy(1'b1, "busy_after_start");
    wait_done(w8 ? 3 : DIGITS + 1);
  endtask

  function automatic logic [W-1:0] rand_bcd();
    logic [W-1:0] v;
    for (int i = 0; i < DIGITS; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
    return v;
  endfunction

  // ---------------- main sequence -----------------------------------------
  initial begin
    logic [W-1:0] ra, rb;
    logic         radd, rbcd, rw8, rci;

    #1;
    checks++;
    if ({S, CO, VO, NO, ZO, BUSY, DONE} !== '0) begin
      errors++;
      $display("FAIL reset_state: got S=%h C=%b V=%b N=%b Z=%b BUSY=%b DONE=%b, expected all 0",
               S, CO, VO, NO, ZO, BUSY, DONE);
    end
    repeat (2) @(negedge CLK);
    #2 RST_N = 1'b1;

    // Directed cases with hand-derived results.
    run_op(16'h0099, 16'h0001, 1'b1, 1'b1, 1'b0, 1'b0, '{16'h0100, 1'b0, 1'b0, 1'b0, 1'b0});
    run_op(16'h0000, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b1, '{16'h9999, 1'b0, 1'b0, 1'b1, 1'b0});
    run_op(16'h7FFF, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0, '{16'h8000, 1'b0, 1'b1, 1'b1, 1'b0});
    run_op(16'h8000, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b1, '{16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0});
    run_op(16'h1299, 16'hAB01, 1'b1, 1'b1, 1'b1, 1'b0, '{16'h1200, 1'b1, 1'b0, 1'b0, 1'b1});

    // START pulsed while busy must be ignored.
    issue(16'h1234, 16'h1111, 1'b1, 1'b0, 1'b0, 1'b0, '{16'h2345, 1'b0, 1'b0, 1'b0, 1'b0});
    @(negedge CLK);
    START = 1'b0;
    @(negedge CLK);
    A = 16'hFFFF; B = 16'hFFFF; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    wait_done(DIGITS + 1 - 2);
    repeat (8) @(negedge CLK);
    check_busy(1'b0, "busy_after_ignored_start");

    // START held through the DONE cycle: second op starts with no idle cycle.
    issue(16'h0250, 16'h0125, 1'b0, 1'b1, 1'b0, 1'b1, '{16'h0125, 1'b1, 1'b0, 1'b0, 1'b0});
    @(negedge CLK);
    A = 16'h4321; B = 16'h1234; ADD = 1'b1; BCD = 1'b1; W8 = 1'b1; CI = 1'b1;
    q.push_back(ref_model(16'h4321, 16'h1234, 1'b1, 1'b1, 1'b1, 1'b1));
    pushed++;
    wait_done(DIGITS + 1);
    @(negedge CLK);
    START = 1'b0;
    scramble();
    check_busy(1'b1, "busy_back_to_back");
    wait_done(3);

    // Reset during RUN after two digits: outputs clear at once, no DONE.
    @(negedge CLK);
    A = 16'h5555; B = 16'h1111; ADD = 1'b1; BCD = 1'b0; W8 = 1'b0; CI = 1'b0;
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    repeat (2) @(negedge CLK);
    #2 RST_N = 1'b0;
    #1;
    checks++;
    if ({S, CO, VO, NO, ZO, BUSY, DONE} !== '0) begin
      errors++;
      $display("FAIL reset_mid_run: got S=%h C=%b V=%b N=%b Z=%b BUSY=%b DONE=%b, expected all 0",
               S, CO, VO, NO, ZO, BUSY, DONE);
    end
    repeat (3) @(negedge CLK);
    #2 RST_N = 1'b1;
    run_op(16'h0999, 16'h0001, 1'b1, 1'b1, 1'b0, 1'b0, '{16'h1000, 1'b0, 1'b0, 1'b0, 1'b0});

    // Randomized operations against the reference model.
    for (int k = 0; k < 60; k++) begin
      radd = 1'($urandom);
      rbcd = 1'($urandom);
      rw8  = 1'($urandom);
      rci  = 1'($urandom);
      if (rbcd) begin
        ra = rand_bcd();
        rb = rand_bcd();
        if (rw8) begin
          ra[W-1:8] = (W-8)'($urandom);
          rb[W-1:8] = (W-8)'($urandom);
        end
      end else begin
        ra = W'($urandom);
        rb = W'($urandom);
      end
      run_op(ra, rb, radd, rbcd, rw8, rci, ref_model(ra, rb, radd, rbcd, rw8, rci));
    end

    repeat (4) @(negedge CLK);
    checks++;
    if (done_count != pushed || q.size() != 0) begin
      errors++;
      $display("FAIL done_count: got %0d DONE pulses with %0d pending, expected %0d pulses",
               done_count, q.size(), pushed);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_serial_alu.md
Name: bcd_serial_alu

Overview:
Multi-digit binary/BCD add/subtract unit. Processes one 4-bit digit per clock, LSB digit first, with a START/DONE handshake. Successor to the single-nibble combinational adder. Serves the 65C816 ADC/SBC path for 8-bit and 16-bit accumulator widths, and any wider DIGITS setting. Produces result plus C, V, N, Z flags.

Parameters:
DIGITS, 4, number of 4-bit digits; datapath width W = 4*DIGITS; must be even and >= 2.

Ports:
CLK  input  1  rising-edge clock
RST_N  input  1  asynchronous active-low reset
START  input  1  request; sampled only in IDLE
ADD  input  1  1 = add, 0 = subtract (A - B - ~CI)
BCD  input  1  1 = decimal mode, 0 = binary
W8  input  1  1 = operate on low 8 bits only (2 digits)
CI  input  1  carry in (subtract: 1 = no borrow)
A  input  W  operand A
B  input  W  operand B
S  output  W  result, held until next completion
CO  output  1  carry out (subtract: 1 = no borrow)
VO  output  1  signed overflow
NO  output  1  result MSB (bit 7 if W8, else bit W-1)
ZO  output  1  result zero (low byte if W8, else all W bits)
BUSY  output  1  operation in progress
DONE  output  1  one-cycle completion pulse

Behaviour:
- Reset (RST_N low, asynchronous): state IDLE. S=0, CO=0, VO=0, NO=0, ZO=0, BUSY=0, DONE=0. Digit counter=0. Internal operand registers cleared.
- States: IDLE, RUN.
- IDLE with START=1 at a CLK edge:
  - latch A, B, ADD, BCD, W8, CI into internal registers; counter=0.
  - N = 2 if W8, else DIGITS.
  - go to RUN; BUSY=1 from that edge.
- IDLE with START=0: hold state and all outputs.
- RUN: each edge processes digit[counter] using the running carry (initialised to latched CI), then counter+1.
- On the edge that processes digit N-1:
  - write S and flags.
  - DONE=1 for exactly one cycle; BUSY=0; return to IDLE.
  - Total latency: DONE is high in the cycle after the (N+1)th edge counted from the START edge.
- START while BUSY: ignored, no queueing.
- START high during the DONE cycle: accepted, because the state is IDLE. Back-to-back operations have no bubble.
- Inputs changing during RUN have no effect; operands are latched at START.
- Per-digit arithmetic, with a = A digit and b' = B digit XOR {4{~ADD}}:
  - binary sum: {bc, bs} = a + b' + c.
  - Add: dc = bc | (bs[3] & (bs[2] | bs[1])). If BCD and dc, digit = bs + 6 mod 16; else digit = bs. Carry out = dc when BCD, else bc.
  - Subtract: dc = ~bc. If BCD and dc, digit = bs + 10 mod 16; else digit = bs. Carry out = bc in both modes.
  - Invalid BCD digits (A–F) follow the same formulas; no detection or saturation.
- Flags are computed on the final processed digit:
  - VO = ~(a[3] ^ b'[3]) & (a[3] ^ bs[3]), using the uncorrected binary sum in both modes.
  - CO = final carry out.
  - NO and ZO are taken from the corrected result.
- W8=1: S[W-1:8] = latched A[W-1:8] (upper accumulator byte preserved). B upper bits are ignored.
- Reset asserted mid-operation: abort immediately to reset values; no DONE pulse.

Test Plan:
- DIGITS=4, BCD add, A=0x0099, B=0x0001, CI=0, W8=0 -> DONE 5 edges after the START edge; S=0x0100, CO=0, ZO=0, NO=0; BUSY high for 4 cycles.
- BCD subtract, A=0x0000, B=0x0001, CI=1 -> S=0x9999, CO=0, NO=1, ZO=0.
- Binary add, A=0x7FFF, B=0x0001, CI=0 -> S=0x8000, VO=1, NO=1, CO=0. Binary subtract, A=0x8000, B=0x0001, CI=1 -> S=0x7FFF, VO=1, CO=1.
- W8 BCD add, A=0x1299, B=0xAB01, CI=0 -> DONE after 2 RUN edges; S=0x1200, CO=1, ZO=1, NO=0.
- Handshake: START pulsed again while BUSY -> ignored, single DONE. START held high through the DONE cycle -> second operation begins with no idle cycle, and its DONE arrives N+1 edges later.
- RST_N pulled low mid-RUN (after 2 digits) -> all outputs 0 asynchronously, no DONE. After release, a new START completes normally.
